rf_write_driver: RTL
====================

Name: rf_write_driver

Overview:
- Drives the single write port (RegWr/rw/Di) of the 32x32 register file.
- Merges two producers:
  - the ALU result path: one write per cycle, always accepted;
  - the slow data-memory/load path: valid/ready handshake, buffered in a small in-order queue.
- Exports per-register busy flags for rs/rt so decode can stall on pending loads.
- Sits between the execute/memory stages and the register file.

Parameters:
DEPTH, 4, load-queue entries (power of 2, >=2)
ADDR_W, 5, register index width
DATA_W, 32, register data width

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  asynchronous, active-high reset
alu_wr  in  1  ALU write request this cycle (never back-pressured)
alu_rw  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU write data
mem_valid  in  1  load write request valid
mem_ready  out  1  queue can accept a load write
mem_rw  in  ADDR_W  load destination register
mem_data  in  DATA_W  load write data
rs  in  ADDR_W  lookup index A
rt  in  ADDR_W  lookup index B
rs_busy  out  1  rs has a pending, not-yet-emitted load write
rt_busy  out  1  rt has a pending, not-yet-emitted load write
RegWr  out  1  register-file write enable (registered)
rw  out  ADDR_W  register-file write index (registered)
Di  out  DATA_W  register-file write data (registered)

Behaviour:
- Reset (async, active-high): queue empty, all entry valid bits 0; RegWr=0, rw=0, Di=0. Reset mid-stream discards all queued writes.
- Register 0 filter:
  - alu_wr with alu_rw==0 is ignored; it does not emit and does not squash.
  - A load with mem_rw==0 is accepted (handshake completes) but is not enqueued.
- Handshake:
  - mem_ready = (count < DEPTH), derived from registered state only.
  - A transfer occurs at a posedge with mem_valid && mem_ready.
  - The producer holds mem_rw/mem_data stable until the transfer.
- Output stage, evaluated each posedge, in priority order:
  1. Effective alu_wr: RegWr<=1, rw<=alu_rw, Di<=alu_data.
  2. Otherwise, queue non-empty: pop the head. If the head is valid, RegWr<=1 with its rw/Di. If it is squashed, RegWr<=0 (the bubble costs one cycle).
  3. Otherwise: RegWr<=0; rw and Di hold.
- Latency:
  - ALU request at edge N appears on RegWr/rw/Di after edge N. The register file commits on the following negedge.
  - A load enqueued at edge N is poppable from edge N+1 onward.
- Ordering (WAW): an effective alu_wr to register R clears the valid bit of every queued entry targeting R at the same edge. The older load must never overwrite the newer ALU value.
- Simultaneous events:
  - Enqueue and pop in the same edge: both happen; count unchanged.
  - A load enqueued in the same edge as an ALU write to the same R is NOT squashed. It is treated as younger and is emitted later.
- Scoreboard:
  - rs_busy = (rs!=0) && some valid queued entry has rw==rs. rt_busy is the same for rt.
  - Combinational over current queue state.
  - The output register itself is never counted busy, because it commits before the next read.
- Queue: circular buffer with rd/wr pointers of log2(DEPTH) bits plus a count of 0..DEPTH. Pointers wrap modulo DEPTH.
- Full: mem_ready=0 even if a pop occurs in the same cycle.
- Empty with no alu_wr: RegWr deasserts the next cycle.

Decomposition:
- Shared package:
  - ADDR_W/DATA_W constants;
  - REG_ZERO=0;
  - a write-request struct {valid, rw, data}, reusable by the register-file bench.
- One natural sub-module: rf_wq_fifo. It holds the circular queue with per-entry valid bits, a squash-by-address input and an address-match output.
- The top level holds the priority mux and the output register.

Test Plan:
- Reset: assert rst mid-operation with 3 loads queued -> RegWr=0, rw=0, Di=0 immediately; mem_ready=1; no queued write ever emitted.
- Priority: alu_wr every cycle (rw=5..8) while loads to r9, r10 are queued -> loads emitted only after alu_wr drops, in order r9 then r10.
- Full queue: 4 loads with no pops (ALU busy) -> mem_ready=0 on the 5th attempt; the 5th load is accepted only after the first pop.
- WAW squash: queue load r3=0xAAAA0000, then alu_wr r3=0x11 -> emits r3=0x11 and one RegWr=0 bubble; r3 ends 0x11; rs_busy(r3) falls the same edge.
- Scoreboard and zero register: load r7 queued -> rs=7 gives rs_busy=1 until its pop edge. Load to r0 and alu_wr to r0 -> no RegWr; rs=0 gives busy=0.
- Wrap-around: 10 back-to-back loads with alternating pops -> pointers wrap; emitted order and data match send order exactly.

Source files
------------

// File: rtl/rf_write_driver_pkg.sv
// Shared constants and types for the register-file write driver and its benches.
package rf_write_driver_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  // One register-file write request; also usable by a register-file bench.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rw;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rf_write_driver_if.sv
// Producer/decode/register-file signal bundle around the write driver.
// master = surrounding pipeline, slave = rf_write_driver.
interface rf_write_driver_if #(
  parameter int ADDR_W = rf_write_driver_pkg::ADDR_W,
  parameter int DATA_W = rf_write_driver_pkg::DATA_W
);

  logic              alu_wr;
  logic [ADDR_W-1:0] alu_rw;
  logic [DATA_W-1:0] alu_data;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_rw;
  logic [DATA_W-1:0] mem_data;

  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic              rs_busy;
  logic              rt_busy;

  logic              RegWr;
  logic [ADDR_W-1:0] rw;
  logic [DATA_W-1:0] Di;

  modport master (
    output alu_wr, alu_rw, alu_data,
    output mem_valid, mem_rw, mem_data,
    output rs, rt,
    input  mem_ready, rs_busy, rt_busy,
    input  RegWr, rw, Di
  );

  modport slave (
    input  alu_wr, alu_rw, alu_data,
    input  mem_valid, mem_rw, mem_data,
    input  rs, rt,
    output mem_ready, rs_busy, rt_busy,
    output RegWr, rw, Di
  );

endinterface

// File: rtl/rf_wq_fifo.sv
// In-order load-write queue with per-entry valid bits. Entries can be squashed
// by destination address (WAW protection) and looked up by address (busy flags).
module rf_wq_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_rw_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              squash_i,
  input  logic [ADDR_W-1:0] squash_rw_i,
  input  logic [ADDR_W-1:0] lookup_a_i,
  input  logic [ADDR_W-1:0] lookup_b_i,
  output logic              full_o,
  output logic              empty_o,
  output logic              head_valid_o,
  output logic [ADDR_W-1:0] head_rw_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic              hit_a_o,
  output logic              hit_b_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);

  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]    cnt_q;
  logic [DEPTH-1:0]  vld_q;
  logic [ADDR_W-1:0] rw_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic              push_ok, pop_ok;

  // DEPTH is a power of two, so the count MSB alone marks "full".
  assign full_o  = cnt_q[PTR_W];
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  assign head_valid_o = vld_q[rd_ptr_q];
  assign head_rw_o    = rw_q[rd_ptr_q];
  assign head_data_o  = data_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (push_ok && !pop_ok)      cnt_q <= cnt_q + CNT_ONE;
      else if (pop_ok && !push_ok) cnt_q <= cnt_q - CNT_ONE;
    end
  end

  // Valid bits: squash only hits entries already queued; a same-edge push is younger.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (squash_i && (rw_q[i] == squash_rw_i)) vld_q[i] <= 1'b0;
      end
      if (pop_ok)  vld_q[rd_ptr_q] <= 1'b0;
      if (push_ok) vld_q[wr_ptr_q] <= 1'b1;
    end
  end

  // Payload storage; meaningless unless the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      rw_q[wr_ptr_q]   <= push_rw_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Address match against every live entry.
  always_comb begin
    hit_a_o = 1'b0;
    hit_b_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (rw_q[i] == lookup_a_i)) hit_a_o = 1'b1;
      if (vld_q[i] && (rw_q[i] == lookup_b_i)) hit_b_o = 1'b1;
    end
  end

endmodule

// File: rtl/rf_write_driver.sv
// Register-file write port driver: ALU writes win every cycle, queued loads
// drain in order when the ALU is idle, and newer ALU writes squash older loads.
module rf_write_driver #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = rf_write_driver_pkg::ADDR_W,
  parameter int DATA_W = rf_write_driver_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  rf_write_driver_if.slave    wr_if
);

  import rf_write_driver_pkg::*;

  logic              alu_eff, push, pop;
  logic              q_full, q_empty, head_valid, hit_a, hit_b;
  logic [ADDR_W-1:0] head_rw;
  logic [DATA_W-1:0] head_data;

  logic              regwr_q, regwr_d;
  logic [ADDR_W-1:0] rw_q, rw_d;
  logic [DATA_W-1:0] di_q, di_d;

  // Writes to r0 are dropped: the ALU one neither emits nor squashes,
  // the load one completes its handshake but never enters the queue.
  assign alu_eff = wr_if.alu_wr && (wr_if.alu_rw != REG_ZERO);
  assign wr_if.mem_ready = !q_full;
  assign push = wr_if.mem_valid && !q_full && (wr_if.mem_rw != REG_ZERO);
  assign pop  = !alu_eff && !q_empty;

  rf_wq_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_rw_i    (wr_if.mem_rw),
    .push_data_i  (wr_if.mem_data),
    .pop_i        (pop),
    .squash_i     (alu_eff),
    .squash_rw_i  (wr_if.alu_rw),
    .lookup_a_i   (wr_if.rs),
    .lookup_b_i   (wr_if.rt),
    .full_o       (q_full),
    .empty_o      (q_empty),
    .head_valid_o (head_valid),
    .head_rw_o    (head_rw),
    .head_data_o  (head_data),
    .hit_a_o      (hit_a),
    .hit_b_o      (hit_b)
  );

  // The output register is never reported busy: it commits before decode reads.
  assign wr_if.rs_busy = (wr_if.rs != REG_ZERO) && hit_a;
  assign wr_if.rt_busy = (wr_if.rt != REG_ZERO) && hit_b;

  // Priority mux: ALU, then queue head (a squashed head yields a bubble), else idle.
  always_comb begin
    regwr_d = 1'b0;
    rw_d    = rw_q;
    di_d    = di_q;
    if (alu_eff) begin
      regwr_d = 1'b1;
      rw_d    = wr_if.alu_rw;
      di_d    = wr_if.alu_data;
    end else if (!q_empty && head_valid) begin
      regwr_d = 1'b1;
      rw_d    = head_rw;
      di_d    = head_data;
    end
  end

  // Registered write port toward the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwr_q <= 1'b0;
      rw_q    <= '0;
      di_q    <= '0;
    end else begin
      regwr_q <= regwr_d;
      rw_q    <= rw_d;
      di_q    <= di_d;
    end
  end

  assign wr_if.RegWr = regwr_q;
  assign wr_if.rw    = rw_q;
  assign wr_if.Di    = di_q;

endmodule
